// File: rtl/shared_ram_pkg.sv
// Shared types for the shared_ram memory responder: FSM state encoding and read pipeline stage.
package shared_ram_pkg;

   localparam int unsigned DATA_W = 16;
   localparam int unsigned TAG_W  = 2;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WACK = 2'd1,
      READ = 2'd2
   } state_t;

   // One read-pipeline stage: word plus the client it belongs to
   typedef struct packed {
      logic              valid;
      logic [TAG_W-1:0]  tag;
      logic [DATA_W-1:0] data;
   } stage_t;

endpackage

// File: rtl/shared_ram_bram.sv
// Simple dual-port block RAM: one write port, one registered read port, no array reset.
module shared_ram_bram #(
   parameter int unsigned DN  = 16,
   parameter int unsigned MAW = 12
) (
   input  logic           clk,
   input  logic           we,
   input  logic [MAW-1:0] wr_addr,
   input  logic [DN-1:0]  wr_data,
   input  logic           re,
   input  logic [MAW-1:0] rd_addr,
   output logic [DN-1:0]  rd_data
);

   localparam int unsigned DEPTH = 1 << MAW;

   logic [DN-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we) mem[wr_addr] <= wr_data;
      if (re) rd_data <= mem[rd_addr];
   end

endmodule

// File: rtl/shared_ram.sv
// Multi-client on-chip memory responder: single-word writes, BURST-word reads, shared return bus.
// Define SHARED_RAM_PRIO_EN for fixed priority (lowest index wins); default is round-robin.
module shared_ram
   import shared_ram_pkg::*;
#(
   parameter int unsigned AN    = 24,
   parameter int unsigned DN    = DATA_W,
   parameter int unsigned IN    = 4,
   parameter int unsigned BURST = 8,
   parameter int unsigned MAW   = 12
) (
   input  logic          clkSYS,
   input  logic          n_reset,
   input  logic [AN-1:0] arb_addr [IN],
   input  logic [DN-1:0] arb_data [IN],
   input  logic [IN-1:0] arb_wr,
   input  logic [IN-1:0] arb_req,
   output logic [IN-1:0] arb_ack,
   output logic [DN-1:0] arb_data_out,
   output logic [IN-1:0] arb_valid,
   output logic          busy
);

   localparam int unsigned TW = (IN > 1) ? $clog2(IN) : 1;
   localparam int unsigned CW = (BURST > 1) ? $clog2(BURST) : 1;

   state_t          state_q, state_d;
   logic            grant_found;
   logic [TW-1:0]   grant_idx;
   logic [AN-1:0]   sel_addr;
   logic [MAW-1:0]  wr_addr;
   logic [DN-1:0]   wr_data;
   logic [MAW-1:0]  rd_addr;
   logic [DN-1:0]   rd_data;
   logic            take, mem_we, rd_en;
   logic [IN-1:0]   ack_d, valid_d;
   logic            busy_d;
   logic [MAW-1:0]  base_q;
   logic [TW-1:0]   tag_q;
   logic [CW-1:0]   cnt_q;
   logic            rd_vld_q;
   logic [TW-1:0]   rd_tag_q;
   stage_t          ram_stg;

`ifdef SHARED_RAM_PRIO_EN
   // Fixed priority: lowest pending index wins
   always_comb begin
      grant_found = 1'b0;
      grant_idx   = '0;
      for (int i = int'(IN) - 1; i >= 0; i--) begin
         if (arb_req[TW'(i)]) begin
            grant_found = 1'b1;
            grant_idx   = TW'(i);
         end
      end
   end
`else
   logic [TW-1:0] last_q;
   logic [TW-1:0] cand;

   // Round-robin: search starts one past the last granted client
   always_comb begin
      grant_found = 1'b0;
      grant_idx   = '0;
      cand        = '0;
      for (int i = 1; i <= int'(IN); i++) begin
         cand = TW'((32'(last_q) + 32'(i)) % IN);
         if (!grant_found && arb_req[cand]) begin
            grant_found = 1'b1;
            grant_idx   = cand;
         end
      end
   end

   always_ff @(posedge clkSYS or negedge n_reset) begin
      if (!n_reset)  last_q <= TW'(IN - 1);
      else if (take) last_q <= grant_idx;
   end
`endif

   assign sel_addr = arb_addr[grant_idx];
   assign wr_addr  = sel_addr[MAW-1:0];
   assign wr_data  = arb_data[grant_idx];
   assign rd_addr  = base_q + MAW'(cnt_q);

   always_ff @(posedge clkSYS or negedge n_reset) begin
      if (!n_reset) state_q <= IDLE;
      else          state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:    if (grant_found) state_d = arb_wr[grant_idx] ? WACK : READ;
         WACK:    state_d = IDLE;
         READ:    if (cnt_q == CW'(BURST - 1)) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Grant in IDLE acks on the next cycle for both writes and reads
   always_comb begin
      take   = 1'b0;
      mem_we = 1'b0;
      rd_en  = 1'b0;
      ack_d  = '0;
      unique case (state_q)
         IDLE: begin
            if (grant_found) begin
               take             = 1'b1;
               mem_we           = arb_wr[grant_idx];
               ack_d[grant_idx] = 1'b1;
            end
         end
         READ:    rd_en = 1'b1;
         default: ;
      endcase
   end

   shared_ram_bram #(
      .DN  (DN),
      .MAW (MAW)
   ) u_bram (
      .clk     (clkSYS),
      .we      (mem_we),
      .wr_addr (wr_addr),
      .wr_data (wr_data),
      .re      (rd_en),
      .rd_addr (rd_addr),
      .rd_data (rd_data)
   );

   always_comb begin
      ram_stg.valid = rd_vld_q;
      ram_stg.tag   = TAG_W'(rd_tag_q);
      ram_stg.data  = DATA_W'(rd_data);
   end

   always_comb begin
      valid_d = '0;
      if (ram_stg.valid) valid_d[ram_stg.tag] = 1'b1;
   end

   // Busy covers the FSM and every word still in flight
   assign busy_d = (state_d != IDLE) || rd_en || rd_vld_q;

   always_ff @(posedge clkSYS or negedge n_reset) begin
      if (!n_reset) begin
         base_q       <= '0;
         tag_q        <= '0;
         cnt_q        <= '0;
         rd_vld_q     <= 1'b0;
         rd_tag_q     <= '0;
         arb_ack      <= '0;
         arb_valid    <= '0;
         arb_data_out <= '0;
         busy         <= 1'b0;
      end else begin
         if (take) begin
            base_q <= wr_addr;
            tag_q  <= grant_idx;
            cnt_q  <= '0;
         end else if (rd_en) begin
            cnt_q  <= cnt_q + CW'(1);
         end
         rd_vld_q  <= rd_en;
         rd_tag_q  <= tag_q;
         arb_ack   <= ack_d;
         arb_valid <= valid_d;
         if (ram_stg.valid) arb_data_out <= DN'(ram_stg.data);
         busy      <= busy_d;
      end
   end

endmodule
